// File: rtl/seq_mul4.sv
// Sequential shift-and-add unsigned multiplier.
// One partial-product add/shift per clock over a WIDTH-bit ripple adder.
module seq_mul4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH:0]     w_carry;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  assign w_carry[0] = 1'b0;

  // Addend mux and full-adder ripple chain over the upper half of acc.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_addend[i] = r_acc[0] ? r_mcand[i] : 1'b0;
    assign w_sum[i] = r_acc[WIDTH+i] ^ w_addend[i]
                    ^ w_carry[i];
    assign w_carry[i+1] =
        (r_acc[WIDTH+i] & w_addend[i])
      | (r_acc[WIDTH+i] & w_carry[i])
      | (w_addend[i] & w_carry[i]);
  end

  assign w_acc_nxt = {w_carry[WIDTH], w_sum,
                      r_acc[WIDTH-1:1]};
  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_p     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_p     <= w_acc_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign p    = r_p;

endmodule

// File: tb/tb_seq_mul4.sv
// Self-checking bench for seq_mul4: vector table,
// corner-case sequences and random ops against a*b.
module tb_seq_mul4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int errs   = 0;
  int checks = 0;

  seq_mul4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] vp;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Full operation from IDLE with latency and hold checks.
  task automatic do_op(input logic [3:0] ta,
                       input logic [3:0] tb_,
                       input logic [7:0] exp);
    logic [7:0] p_prev;
    int nb;
    p_prev = p;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      if (busy) begin
        nb++;
        check("p_hold", p, p_prev);
      end
      @(negedge clk);
    end
    check("busy_cycles", nb, 4);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("product", p, exp);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("p_after", p, exp);
  endtask

  vec_t vecs[8];
  int   nd;
  int   last_d;
  logic [7:0] p_seen;

  initial begin
    vecs[0] = '{4'h7, 4'h9, 8'h3F};
    vecs[1] = '{4'hF, 4'hF, 8'hE1};
    vecs[2] = '{4'h0, 4'hF, 8'h00};
    vecs[3] = '{4'h1, 4'h0, 8'h00};
    vecs[4] = '{4'h8, 4'h8, 8'h40};
    vecs[5] = '{4'hF, 4'h1, 8'h0F};
    vecs[6] = '{4'h1, 4'hF, 8'h0F};
    vecs[7] = '{4'hC, 4'hB, 8'h84};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 8'h00);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vp);

    // start during RUN is ignored; a/b change freely
    @(negedge clk);
    a = 4'hA; b = 4'h5; start = 1'b1;
    @(negedge clk);
    nd = 0; p_seen = '0;
    for (int k = 0; k < 14; k++) begin
      start = busy;
      a = 4'h3 + 4'(k); b = 4'h3 ^ 4'(k);
      if (done) begin
        nd++;
        p_seen = p;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore_start_dones", nd, 1);
    check("ignore_start_p", p_seen, 8'h32);

    // start held high: one product every 6 cycles
    a = 4'h2; b = 4'h3; start = 1'b1;
    nd = 0; last_d = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) begin
        if (last_d >= 0)
          check("b2b_period", i - last_d, 6);
        else
          check("b2b_first", i, 4);
        check("b2b_p", p, 8'h06);
        last_d = i;
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_count", nd, 4);
    @(negedge clk);
    @(negedge clk);

    // reset in the 2nd RUN cycle aborts the op
    a = 4'hF; b = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_p", p, 8'h00);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("abort_no_done", nd, 0);
    do_op(4'h1, 4'h1, 8'h01);

    // random ops against plain multiplication
    for (int n = 0; n < 30; n++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      do_op(ra, rb, 8'(ra) * 8'(rb));
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
